// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, program ROM, control and decode.
// FETCH_PERF_CNT_EN adds the fetch/stall counter outputs.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  run;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  mem_enable;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_instruction;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]           fetch_count;
  logic [31:0]           stall_count;
`endif

  modport master (
    input  run, redirect, redirect_pc, mem_instruction, instr_ready,
    output mem_enable, mem_address, instr_valid, instr, instr_pc, fault
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, stall_count
`endif
  );

  modport slave (
    output run, redirect, redirect_pc, mem_instruction, instr_ready,
    input  mem_enable, mem_address, instr_valid, instr, instr_pc, fault
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, stall_count
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program-memory requester: PC, ROM read, instruction queue to decode.
// FETCH_PERF_CNT_EN adds fetch/stall performance counters.
//
// state | meaning
// IDLE  | not fetching, waiting for run
// FETCH | issuing one ROM read per cycle while the queue has room
// FAULT | PC out of range or misaligned; held until redirect
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h00400000,
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] word_offset;
  logic                  pc_bad;
  logic                  issue;
  logic                  pop;
  logic                  q_valid;
  logic                  queue_room;

  logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;

  assign word_offset = pc_q - TEXT_BASE;
  assign pc_bad      = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) ||
                       ((word_offset >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));

  assign q_valid    = (count_q != '0);
  // Redirect wins over the handshake: a head offered during redirect is dropped.
  assign pop        = q_valid && bus.instr_ready && !bus.redirect;
  assign queue_room = (count_q < CNT_W'(QUEUE_DEPTH)) || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (bus.redirect) begin
      state_d = bus.run ? FETCH : IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (bus.run) state_d = FETCH;
        FETCH: begin
          if (!bus.run)    state_d = IDLE;
          else if (pc_bad) state_d = FAULT;
          else             issue   = queue_room;
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_q <= TEXT_BASE;
    else if (bus.redirect) pc_q <= bus.redirect_pc;
    else if (issue)        pc_q <= pc_q + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (issue) begin
        q_instr[wr_ptr_q] <= bus.mem_instruction;
        q_pc[wr_ptr_q]    <= pc_q;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({issue, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.mem_enable  = issue;
  assign bus.mem_address = word_offset >> 2;
  assign bus.instr_valid = q_valid;
  assign bus.instr       = q_valid ? q_instr[rd_ptr_q] : '0;
  assign bus.instr_pc    = q_valid ? q_pc[rd_ptr_q] : '0;
  assign bus.fault       = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (issue) fetch_count_q <= fetch_count_q + 32'd1;
      if ((state_q == FETCH) && bus.run && !issue) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected
// {pc, instr} pairs; a negedge monitor compares every accepted head.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] TEXT_BASE = 32'h00400000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] rom [64];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  instr_fetch_unit #(
    .DATA_WIDTH(32), .MEMORY_DEPTH(64), .TEXT_BASE(32'h00400000), .QUEUE_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.mem_instruction = (bus.mem_address < 32'd64) ? rom[bus.mem_address[5:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.pc  = TEXT_BASE + 32'(4 * idx);
    e.ins = rom[idx];
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_pc"},    bus.instr_pc, 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    chk({tag, "_en"},    32'(bus.mem_enable), 32'd0);
    chk({tag, "_addr"},  bus.mem_address, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fcnt"},  bus.fetch_count, 32'd0);
    chk({tag, "_scnt"},  bus.stall_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    step();
    bus.run      = 1'b0;
    bus.redirect = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted head must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h instr %h, expected no output", bus.instr_pc, bus.instr);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", bus.instr_pc, e.pc);
          chk("pop_instr", bus.instr, e.ins);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 + 32'(i);
    rom[0] = 32'h20080005;
    rom[1] = 32'h20090003;
    rom[2] = 32'h01095020;
    rst_n           = 1'b0;
    bus.run         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;

    // A: three back-to-back fetches with decode always ready
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(i);
    step(); bus.run = 1'b1;
    step(); @(negedge clk); chk("a_en0", 32'(bus.mem_enable), 32'd1); chk("a_addr0", bus.mem_address, 32'd0);
    step(); @(negedge clk); chk("a_addr1", bus.mem_address, 32'd1);
    step(); @(negedge clk); chk("a_addr2", bus.mem_address, 32'd2);
    step(); bus.run = 1'b0;
    repeat (4) step();
    chk("a_drained", 32'(sb.size()), 32'd0);

    // B: backpressure fills the queue, then resumes at word 2
    do_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(i);
    step(); bus.run = 1'b1;
    step();
    step();
    step(); @(negedge clk);
    chk("b_stall_en", 32'(bus.mem_enable), 32'd0);
    chk("b_stall_addr", bus.mem_address, 32'd2);
    chk("b_head_valid", 32'(bus.instr_valid), 32'd1);
    chk("b_head_pc", bus.instr_pc, 32'h00400000);
    step(); @(negedge clk);
    chk("b_hold_instr", bus.instr, 32'h20080005);
    step(); bus.instr_ready = 1'b1; @(negedge clk);
    chk("b_resume_en", 32'(bus.mem_enable), 32'd1);
    chk("b_resume_addr", bus.mem_address, 32'd2);
    step(); bus.run = 1'b0;
    repeat (4) step();
    chk("b_drained", 32'(sb.size()), 32'd0);

    // C: redirect flushes two queued entries
    do_reset();
    bus.instr_ready = 1'b0;
    push_exp(8);
    step(); bus.run = 1'b1;
    step();
    step();
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h00400020;
    step(); bus.redirect = 1'b0; bus.instr_ready = 1'b1; @(negedge clk);
    chk("c_flush_valid", 32'(bus.instr_valid), 32'd0);
    chk("c_redir_addr", bus.mem_address, 32'd8);
    chk("c_redir_en", 32'(bus.mem_enable), 32'd1);
    step(); bus.run = 1'b0;
    repeat (3) step();
    chk("c_drained", 32'(sb.size()), 32'd0);

    // D: run off the end of ROM, drain in FAULT, recover by redirect
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_exp(i);
    step(); bus.run = 1'b1;
    repeat (63) step();
    step(); bus.instr_ready = 1'b0;
    step(); @(negedge clk);
    chk("d_oor_en", 32'(bus.mem_enable), 32'd0);
    chk("d_oor_addr", bus.mem_address, 32'd64);
    step(); @(negedge clk);
    chk("d_fault", 32'(bus.fault), 32'd1);
    chk("d_fault_en", 32'(bus.mem_enable), 32'd0);
    chk("d_fault_valid", 32'(bus.instr_valid), 32'd1);
    step(); bus.instr_ready = 1'b1;
    step();
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h00400000;
    push_exp(0);
    step(); bus.redirect = 1'b0; @(negedge clk);
    chk("d_clear_fault", 32'(bus.fault), 32'd0);
    chk("d_restart_en", 32'(bus.mem_enable), 32'd1);
    chk("d_restart_addr", bus.mem_address, 32'd0);
    step(); bus.run = 1'b0;
    repeat (3) step();
    chk("d_drained", 32'(sb.size()), 32'd0);

    // E: misaligned and below-base redirect targets
    step(); bus.run = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h00400002;
    step(); bus.redirect = 1'b0; @(negedge clk);
    chk("e_mis_en", 32'(bus.mem_enable), 32'd0);
    step(); @(negedge clk);
    chk("e_mis_fault", 32'(bus.fault), 32'd1);
    chk("e_mis_fault_en", 32'(bus.mem_enable), 32'd0);
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h003FFFFC;
    step(); bus.redirect = 1'b0; @(negedge clk);
    chk("e_low_clear", 32'(bus.fault), 32'd0);
    chk("e_low_en", 32'(bus.mem_enable), 32'd0);
    chk("e_low_addr", bus.mem_address, 32'h3FFFFFFF);
    step(); @(negedge clk);
    chk("e_low_fault", 32'(bus.fault), 32'd1);
    chk("e_low_valid", 32'(bus.instr_valid), 32'd0);
    step(); bus.run = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h00400000;
    step(); bus.redirect = 1'b0; @(negedge clk);
    chk("e_recover", 32'(bus.fault), 32'd0);

    // F: asynchronous reset in the middle of a burst
    bus.instr_ready = 1'b0;
    step(); bus.run = 1'b1;
    step();
    step();
    step(); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("f_async");
    bus.run = 1'b0;
    bus.instr_ready = 1'b1;
    step();
    step(); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(i);
    step(); bus.run = 1'b1;
    step(); @(negedge clk);
    chk("f_first_en", 32'(bus.mem_enable), 32'd1);
    chk("f_first_addr", bus.mem_address, 32'd0);
    step();
    step();
    step(); bus.run = 1'b0;
    repeat (3) step();
    chk("f_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("f_fetch_count", bus.fetch_count, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
